// File: rtl/bitstream_detect_ctrl.sv
// Session controller for the serial pattern detector.
// Latches pattern/window/target on an accepted start, clears and arms the
// detector, counts qualified bits and matches, and ends the session on
// target, window expiry or abort.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | post-reset, no session has run yet
//   ARM    | one cycle: detector history cleared, shifting held off
//   RUN    | detector enabled, valid bits and matches being counted
//   DONE   | session ended, counters and status frozen until restart
module bitstream_detect_ctrl #(
   parameter int PW = 5,
   parameter int CW = 16,
   parameter int MW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [PW-1:0] cfg_pattern,
   input  logic [CW-1:0] cfg_win,
   input  logic [MW-1:0] cfg_target,
   input  logic          din_valid,
   input  logic          det_flag,
   output logic          det_clr,
   output logic          det_en,
   output logic [PW-1:0] det_pattern,
   output logic          busy,
   output logic          done,
   output logic [1:0]    status,
   output logic [MW-1:0] match_cnt,
   output logic [CW-1:0] bit_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [1:0] ST_NONE   = 2'b00;
   localparam logic [1:0] ST_TARGET = 2'b01;
   localparam logic [1:0] ST_WINDOW = 2'b10;
   localparam logic [1:0] ST_ABORT  = 2'b11;

   localparam logic [CW-1:0] BIT_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [MW-1:0] MATCH_ONE = {{(MW-1){1'b0}}, 1'b1};

   state_t          state_q, state_d;
   logic [PW-1:0]   pattern_q, pattern_d;
   logic [CW-1:0]   win_q, win_d;
   logic [MW-1:0]   target_q, target_d;
   logic [MW-1:0]   match_cnt_q, match_cnt_d;
   logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [1:0]      status_q, status_d;
   logic            done_q, done_d;

   // Next-state, config latch, counters and exit priority
   always_comb begin
      state_d     = state_q;
      pattern_d   = pattern_q;
      win_d       = win_q;
      target_d    = target_q;
      match_cnt_d = match_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      status_d    = status_q;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            // start coinciding with abort is dropped so a stuck abort
            // cannot launch a session that immediately dies
            if (start && !abort) begin
               pattern_d   = cfg_pattern;
               win_d       = cfg_win;
               target_d    = cfg_target;
               match_cnt_d = '0;
               bit_cnt_d   = '0;
               status_d    = ST_NONE;
               state_d     = S_ARM;
            end
         end
         S_ARM: begin
            if (abort) begin
               state_d  = S_DONE;
               status_d = ST_ABORT;
               done_d   = 1'b1;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (din_valid) begin
               if (bit_cnt_q != '1) begin
                  bit_cnt_d = bit_cnt_q + BIT_ONE;
               end
               if (det_flag && (match_cnt_q != '1)) begin
                  match_cnt_d = match_cnt_q + MATCH_ONE;
               end
            end
            // exit decisions look at the post-increment counts so the
            // final qualifying bit ends the session on this same edge
            if (abort) begin
               state_d  = S_DONE;
               status_d = ST_ABORT;
               done_d   = 1'b1;
            end else if ((target_q != '0) && (match_cnt_d == target_q)) begin
               state_d  = S_DONE;
               status_d = ST_TARGET;
               done_d   = 1'b1;
            end else if ((win_q != '0) && (bit_cnt_d == win_q)) begin
               state_d  = S_DONE;
               status_d = ST_WINDOW;
               done_d   = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and session registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pattern_q   <= '0;
         win_q       <= '0;
         target_q    <= '0;
         match_cnt_q <= '0;
         bit_cnt_q   <= '0;
         status_q    <= ST_NONE;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pattern_q   <= pattern_d;
         win_q       <= win_d;
         target_q    <= target_d;
         match_cnt_q <= match_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         status_q    <= status_d;
         done_q      <= done_d;
      end
   end

   assign det_clr     = (state_q == S_ARM);
   assign det_en      = (state_q == S_RUN);
   assign busy        = (state_q == S_ARM) || (state_q == S_RUN);
   assign done        = done_q;
   assign det_pattern = pattern_q;
   assign status      = status_q;
   assign match_cnt   = match_cnt_q;
   assign bit_cnt     = bit_cnt_q;

endmodule

// File: tb/tb_bitstream_detect_ctrl.sv
// Bench for bitstream_detect_ctrl: directed sessions plus randomized ones,
// with the expected session outcome computed from a bit-level model of the
// detector and the session end rules.
module tb_bitstream_detect_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, abort;
   logic [4:0]  cfg_pattern;
   logic [15:0] cfg_win;
   logic [7:0]  cfg_target;
   logic        din_valid, det_flag;
   logic        det_clr, det_en, busy, done;
   logic [4:0]  det_pattern;
   logic [1:0]  status;
   logic [7:0]  match_cnt;
   logic [15:0] bit_cnt;

   int n_pass  = 0;
   int n_total = 0;

   bitstream_detect_ctrl #(.PW(5), .CW(16), .MW(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .cfg_pattern (cfg_pattern),
      .cfg_win     (cfg_win),
      .cfg_target  (cfg_target),
      .din_valid   (din_valid),
      .det_flag    (det_flag),
      .det_clr     (det_clr),
      .det_en      (det_en),
      .det_pattern (det_pattern),
      .busy        (busy),
      .done        (done),
      .status      (status),
      .match_cnt   (match_cnt),
      .bit_cnt     (bit_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"},    busy,        0);
      chk({tag, "_done"},    done,        0);
      chk({tag, "_clr"},     det_clr,     0);
      chk({tag, "_en"},      det_en,      0);
      chk({tag, "_status"},  status,      0);
      chk({tag, "_match"},   match_cnt,   0);
      chk({tag, "_bits"},    bit_cnt,     0);
      chk({tag, "_pattern"}, det_pattern, 0);
   endtask

   // One full session. Stream bits are consumed MSB first; after the stream
   // runs out, fill < 0 means random bits, otherwise the constant fill value.
   // abort_at >= 0 raises abort once that many valid bits have been taken.
   task automatic run_session(input string tag, input logic [4:0] pat,
                              input int win, input int tgt,
                              input int nstream, input logic [31:0] stream,
                              input int fill, input int duty,
                              input int abort_at, input bit poke_start);
      int          m, b, hn, consumed, st;
      logic [4:0]  hist, hist2;
      logic        v, a, bitv, flag;
      bit          ended;
      cfg_pattern = pat;
      cfg_win     = 16'(win);
      cfg_target  = 8'(tgt);
      abort       = 1'b0;
      din_valid   = 1'b0;
      det_flag    = 1'b0;
      start       = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_arm_clr"},   det_clr,     1);
      chk({tag, "_arm_busy"},  busy,        1);
      chk({tag, "_arm_en"},    det_en,      0);
      chk({tag, "_arm_pat"},   det_pattern, pat);
      chk({tag, "_arm_bits"},  bit_cnt,     0);
      chk({tag, "_arm_match"}, match_cnt,   0);
      chk({tag, "_arm_stat"},  status,      0);
      cfg_pattern = 5'($urandom);
      cfg_win     = 16'($urandom_range(1, 3));
      cfg_target  = 8'($urandom_range(1, 2));
      start       = poke_start;
      tick();
      start = 1'b0;
      chk({tag, "_run_en"},  det_en,  1);
      chk({tag, "_run_clr"}, det_clr, 0);
      m = 0; b = 0; hn = 0; consumed = 0; hist = '0; ended = 0;
      for (int cyc = 0; cyc < 400 && !ended; cyc++) begin
         v = ($urandom_range(99) < duty);
         a = (abort_at >= 0) && (b >= abort_at);
         if (a) v = 1'b0;
         if (consumed < nstream) bitv = stream[nstream - 1 - consumed];
         else if (fill < 0)      bitv = 1'($urandom_range(1));
         else                    bitv = 1'(fill);
         hist2 = {hist[3:0], bitv};
         if (v) flag = (hn + 1 >= 5) && (hist2 == pat);
         else   flag = 1'($urandom_range(1));
         start     = poke_start && (cyc == 2);
         abort     = a;
         din_valid = v;
         det_flag  = flag;
         tick();
         start = 1'b0;
         if (v) begin
            consumed++;
            hist = hist2;
            hn++;
            if (b < 65535) b++;
            if (flag && m < 255) m++;
         end
         if (a)                          st = 3;
         else if (tgt != 0 && m == tgt)  st = 1;
         else if (win != 0 && b == win)  st = 2;
         else                            st = 0;
         if (st != 0) begin
            ended = 1;
            chk({tag, "_end_done"},   done,      1);
            chk({tag, "_end_status"}, status,    st);
            chk({tag, "_end_busy"},   busy,      0);
            chk({tag, "_end_en"},     det_en,    0);
            chk({tag, "_end_bits"},   bit_cnt,   b);
            chk({tag, "_end_match"},  match_cnt, m);
         end else begin
            chk({tag, "_run_done"},  done,      0);
            chk({tag, "_run_busy"},  busy,      1);
            chk({tag, "_run_bits"},  bit_cnt,   b);
            chk({tag, "_run_match"}, match_cnt, m);
         end
      end
      chk({tag, "_timeout"}, ended, 1);
      abort     = 1'b0;
      din_valid = 1'b1;
      det_flag  = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk({tag, "_post_done"},   done,      0);
         chk({tag, "_post_busy"},   busy,      0);
         chk({tag, "_post_en"},     det_en,    0);
         chk({tag, "_post_status"}, status,    st);
         chk({tag, "_post_bits"},   bit_cnt,   b);
         chk({tag, "_post_match"},  match_cnt, m);
      end
      din_valid = 1'b0;
      det_flag  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      cfg_pattern = 5'b10010; cfg_win = '0; cfg_target = '0;
      din_valid = 1'b0; det_flag = 1'b0;
      tick(); tick();
      chk_zero("reset");
      rst = 1'b0;
      tick();
      chk_zero("idle");

      // T2 target: two matches in 1001010010 end the session on bit 10
      run_session("t2", 5'b10010, 0, 2, 10, 32'b1001010010, -1, 100, -1, 0);
      // T3 window: 8 bits with one embedded match
      run_session("t3", 5'b10010, 8, 3, 8, 32'b01001000, -1, 100, -1, 0);
      // T4 tie: the match on the last window bit reports TARGET
      run_session("t4", 5'b10010, 5, 1, 5, 32'b10010, -1, 100, -1, 0);
      // T5 abort with 50% valid duty after 4 valid bits
      run_session("t5", 5'b10010, 0, 0, 0, 32'b0, -1, 50, 4, 0);

      // start together with abort in DONE is ignored
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("sa_busy",   busy,    0);
      chk("sa_clr",    det_clr, 0);
      chk("sa_status", status,  3);
      tick();
      chk("sa_busy2",  busy,    0);

      // T6 restart from DONE with a new pattern, with starts poked while busy
      run_session("t6", 5'b11001, 0, 1, 10, 32'b0111001000, -1, 100, -1, 1);

      // abort during ARM ends the session with no counts
      cfg_pattern = 5'b10101; cfg_win = 16'd4; cfg_target = 8'd1;
      start = 1'b1;
      tick();
      start = 1'b0; abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("armab_done",   done,      1);
      chk("armab_status", status,    3);
      chk("armab_busy",   busy,      0);
      chk("armab_bits",   bit_cnt,   0);
      tick();
      chk("armab_once",   done,      0);

      // match counter saturates in an unbounded all-zero stream
      run_session("sat", 5'b00000, 0, 0, 0, 32'b0, 0, 100, 270, 0);

      // randomized sessions
      for (int r = 0; r < 8; r++) begin
         int w, t, ab;
         w  = $urandom_range(0, 20);
         t  = $urandom_range(0, 3);
         ab = ($urandom_range(3) == 0 || (w == 0 && t == 0)) ? $urandom_range(2, 30) : -1;
         run_session("rnd", 5'($urandom), w, t, 0, 32'b0, -1,
                     $urandom_range(30, 100), ab, 1'($urandom_range(1)));
      end

      // T1 reset mid-RUN
      cfg_pattern = 5'b10010; cfg_win = '0; cfg_target = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      din_valid = 1'b1; det_flag = 1'b1;
      tick(); tick(); tick();
      chk("t1_pre_busy", busy, 1);
      rst = 1'b1;
      tick(); tick();
      din_valid = 1'b0; det_flag = 1'b0;
      chk_zero("t1");
      rst = 1'b0;
      tick();
      chk_zero("t1_after");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
